// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the decode-stage hazard scheduler.
package hazard_scheduler_pkg;

  // Register index width of the 16-bit core; also sizes the scoreboard rdst field.
  localparam int unsigned REG_W_DEF = 3;

  // Forwarding select encodings for the decode read ports.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StDrain,
    StAck
  } state_e;

  // One in-flight writer tracked in EX, MEM or WB.
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic [REG_W_DEF-1:0] rdst;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scheduler_sb_match.sv
// Compares one decode source against the EX/MEM/WB scoreboard entries.
module hazard_scheduler_sb_match
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  sb_entry_t        ex_i,
  input  sb_entry_t        mem_i,
  input  sb_entry_t        wb_i,
  output logic [1:0]       fwd_sel_o,
  output logic             hit_o,
  output logic             ex_load_o
);

  logic hit_ex, hit_mem, hit_wb;

  // Only an EX-stage load can create a load-use hazard.
  logic unused_mem_read;
  assign unused_mem_read = mem_i.mem_read ^ wb_i.mem_read;

  assign hit_ex  = use_i && ex_i.valid  && ex_i.reg_write  && (ex_i.rdst[REG_W-1:0]  == src_i);
  assign hit_mem = use_i && mem_i.valid && mem_i.reg_write && (mem_i.rdst[REG_W-1:0] == src_i);
  assign hit_wb  = use_i && wb_i.valid  && wb_i.reg_write  && (wb_i.rdst[REG_W-1:0]  == src_i);

  assign hit_o     = hit_ex || hit_mem || hit_wb;
  assign ex_load_o = hit_ex && ex_i.mem_read;

  // Youngest writer wins: EX over MEM over WB.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (hit_ex) begin
      fwd_sel_o = FWD_EX;
    end else if (hit_mem) begin
      fwd_sel_o = FWD_MEM;
    end else if (hit_wb) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard controller: forwarding, load-use stalls, branch flush, interrupt drain.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEF,  // must not exceed REG_W_DEF
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 1           // 1..3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rsrc1,
  input  logic             id_use1,
  input  logic [REG_W-1:0] id_rsrc2,
  input  logic             id_use2,
  input  logic [REG_W-1:0] id_rdst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  input  logic             int_req,
  output logic             stall_out,
  output logic             bubble_out,
  output logic             flush_out,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             int_ack
);

  state_e    state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic      int_pend_q, int_pend_d;
  logic      int_ack_q, int_ack_d;
  sb_entry_t ex_q, ex_d, mem_q, wb_q;

  logic [1:0] sel1, sel2;
  logic       hit1, hit2, ld1, ld2, hazard;

  hazard_scheduler_sb_match #(.REG_W(REG_W)) u_match1 (
    .src_i     (id_rsrc1),
    .use_i     (id_use1),
    .ex_i      (ex_q),
    .mem_i     (mem_q),
    .wb_i      (wb_q),
    .fwd_sel_o (sel1),
    .hit_o     (hit1),
    .ex_load_o (ld1)
  );

  hazard_scheduler_sb_match #(.REG_W(REG_W)) u_match2 (
    .src_i     (id_rsrc2),
    .use_i     (id_use2),
    .ex_i      (ex_q),
    .mem_i     (mem_q),
    .wb_i      (wb_q),
    .fwd_sel_o (sel2),
    .hit_o     (hit2),
    .ex_load_o (ld2)
  );

  // Without forwarding, any RAW match stalls (WB included: its write lands at the same edge).
  assign hazard   = id_valid && (FWD_EN ? (ld1 || ld2) : (hit1 || hit2));
  assign fwd1_sel = FWD_EN ? sel1 : FWD_RF;
  assign fwd2_sel = FWD_EN ? sel2 : FWD_RF;
  assign int_ack  = int_ack_q;

  // FSM next state and stall/bubble/flush outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_out  = 1'b0;
    bubble_out = 1'b0;
    flush_out  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          // Flush overrides any concurrent load-use stall.
          flush_out  = 1'b1;
          bubble_out = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            cnt_d   = 2'(FLUSH_CYCLES - 1);
          end else if (int_pend_q) begin
            state_d = StDrain;
          end
        end else begin
          stall_out  = hazard;
          bubble_out = hazard;
          if (int_pend_q) begin
            state_d = StDrain;
          end
        end
      end
      StFlush: begin
        flush_out  = 1'b1;
        bubble_out = 1'b1;
        cnt_d      = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = int_pend_q ? StDrain : StRun;
        end
      end
      StDrain: begin
        stall_out  = 1'b1;
        bubble_out = 1'b1;
        if (!ex_q.valid && !mem_q.valid && !wb_q.valid) begin
          state_d = StAck;
        end
      end
      StAck: begin
        stall_out  = 1'b1;
        bubble_out = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // A request seen during ACK re-arms the pending flag after the clear.
  always_comb begin
    int_pend_d = (int_pend_q && (state_q != StAck)) || int_req;
    int_ack_d  = (state_d == StAck);
  end

  // Entry issued into EX; bubbles and empty decode slots enter as invalid.
  always_comb begin
    ex_d = '0;
    if (id_valid && !bubble_out) begin
      ex_d.valid               = 1'b1;
      ex_d.reg_write           = id_reg_write;
      ex_d.mem_read            = id_mem_read;
      ex_d.rdst[REG_W-1:0]     = id_rdst;
    end
  end

  // State, scoreboard shift and registered interrupt acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      cnt_q      <= 2'd0;
      int_pend_q <= 1'b0;
      int_ack_q  <= 1'b0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      int_ack_q  <= int_ack_d;
      ex_q       <= ex_d;
      mem_q      <= ex_q;
      wb_q       <= mem_q;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with an expected-response queue and a negedge monitor.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, branch_taken = 1'b0, int_req = 1'b0;
  logic [2:0] id_rsrc1 = '0, id_rsrc2 = '0, id_rdst = '0;

  logic       a_stall, a_bubble, a_flush, a_ack;
  logic [1:0] a_f1, a_f2;
  logic       b_stall, b_bubble, b_flush, b_ack;
  logic [1:0] b_f1, b_f2;

  always #5 clk = ~clk;

  // Forwarding enabled, two-cycle branch flush.
  hazard_scheduler #(.REG_W(3), .FWD_EN(1'b1), .FLUSH_CYCLES(2)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rsrc1     (id_rsrc1),
    .id_use1      (id_use1),
    .id_rsrc2     (id_rsrc2),
    .id_use2      (id_use2),
    .id_rdst      (id_rdst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .branch_taken (branch_taken),
    .int_req      (int_req),
    .stall_out    (a_stall),
    .bubble_out   (a_bubble),
    .flush_out    (a_flush),
    .fwd1_sel     (a_f1),
    .fwd2_sel     (a_f2),
    .int_ack      (a_ack)
  );

  // Forwarding disabled.
  hazard_scheduler #(.REG_W(3), .FWD_EN(1'b0), .FLUSH_CYCLES(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rsrc1     (id_rsrc1),
    .id_use1      (id_use1),
    .id_rsrc2     (id_rsrc2),
    .id_use2      (id_use2),
    .id_rdst      (id_rdst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .branch_taken (branch_taken),
    .int_req      (int_req),
    .stall_out    (b_stall),
    .bubble_out   (b_bubble),
    .flush_out    (b_flush),
    .fwd1_sel     (b_f1),
    .fwd2_sel     (b_f2),
    .int_ack      (b_ack)
  );

  // exp packs {stall, bubble, flush, fwd1[1:0], fwd2[1:0], int_ack}.
  typedef struct {
    string      name;
    bit         dut_b;
    logic [7:0] exp;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] got;
  int         n_vec = 0;
  int         n_err = 0;

  // Monitor: compare one expected response per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      got = cur.dut_b ? {b_stall, b_bubble, b_flush, b_f1, b_f2, b_ack}
                      : {a_stall, a_bubble, a_flush, a_f1, a_f2, a_ack};
      n_vec++;
      if (got !== cur.exp) begin
        n_err++;
        $display("FAIL %s: got stall/bub/flush/f1/f2/ack=%b required %b",
                 cur.name, got, cur.exp);
      end
    end
  end

  task automatic cyc(input string name, input bit b, input logic r, input logic v,
                     input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                     input logic u2, input logic [2:0] rd, input logic rw, input logic mr,
                     input logic br, input logic irq, input logic [7:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = v;
    id_rsrc1     = s1;
    id_use1      = u1;
    id_rsrc2     = s2;
    id_use2      = u2;
    id_rdst      = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    branch_taken = br;
    int_req      = irq;
    item.name    = name;
    item.dut_b   = b;
    item.exp     = e;
    q.push_back(item);
  endtask

  task automatic do_reset(input string name);
    cyc(name, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0);
  endtask

  initial begin
    do_reset("reset");

    // Forwarding distances EX, MEM, WB, none, and EX-over-WB priority.
    cyc("add_r1",   0, 1, 1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("fwd_ex",   0, 1, 1, 1, 1, 4, 1, 5, 1, 0, 0, 0, 8'b0_0_0_01_00_0);
    cyc("fwd_mem",  0, 1, 1, 1, 1, 0, 0, 6, 1, 0, 0, 0, 8'b0_0_0_10_00_0);
    cyc("fwd_wb",   0, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 8'b0_0_0_11_10_0);
    cyc("fwd_none", 0, 1, 1, 1, 1, 5, 1, 6, 1, 0, 0, 0, 8'b0_0_0_00_11_0);
    cyc("fwd_prio", 0, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_01_00_0);
    cyc("use_gate", 0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    do_reset("reset2");

    // Load-use: one stall/bubble cycle, then MEM forwarding.
    cyc("ldd_r2",   0, 1, 1, 7, 1, 0, 0, 2, 1, 1, 0, 0, 8'b0_0_0_00_00_0);
    cyc("ld_use",   0, 1, 1, 2, 1, 4, 1, 3, 1, 0, 0, 0, 8'b1_1_0_01_00_0);
    cyc("ld_fwd",   0, 1, 1, 2, 1, 4, 1, 3, 1, 0, 0, 0, 8'b0_0_0_10_00_0);
    cyc("after_ld", 0, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 8'b0_0_0_00_01_0);
    do_reset("reset3");

    // No forwarding: reader of R5 stalls through EX, MEM and WB.
    cyc("raw_w",     1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 8'b0_0_0_00_00_0);
    for (int i = 0; i < 3; i++) begin
      cyc("raw_stall", 1, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 8'b1_1_0_00_00_0);
    end
    cyc("raw_issue", 1, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 8'b0_0_0_00_00_0);
    do_reset("reset4");

    // Branch with a pending load-use: flush wins; branch in FLUSH is ignored.
    cyc("ldd_r2b",  0, 1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 8'b0_0_0_00_00_0);
    cyc("br_ld",    0, 1, 1, 2, 1, 0, 0, 3, 1, 0, 1, 0, 8'b0_1_1_01_00_0);
    cyc("flush2",   0, 1, 1, 2, 1, 0, 0, 3, 1, 0, 1, 0, 8'b0_1_1_10_00_0);
    cyc("post_fl",  0, 1, 1, 2, 1, 0, 0, 3, 1, 0, 0, 0, 8'b0_0_0_11_00_0);
    do_reset("reset5");

    // Interrupt with three writers in flight: 3 DRAIN cycles, 1 ACK, back to RUN.
    cyc("w_r1",      0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("w_r2",      0, 1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("w_r3_irq",  0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 8'b0_0_0_00_00_0);
    cyc("pend_run",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("drain1",    0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 8'b1_1_0_10_00_0);
    cyc("drain2",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_1_0_00_00_0);
    cyc("drain3",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_1_0_00_00_0);
    cyc("ack",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1_1_0_00_00_1);
    cyc("post_ack",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("no_repeat", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    do_reset("reset6");

    // Asynchronous reset in the middle of DRAIN clears everything at once.
    cyc("w_r4_irq",  0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 8'b0_0_0_00_00_0);
    cyc("pend_run2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("drain_r4",  0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 8'b1_1_0_10_00_0);
    cyc("async_rst", 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("post_rst",  0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);
    cyc("post_rst2", 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 8'b0_0_0_00_00_0);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: %0d responses left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
